// File: rtl/flag_branch_unit_if.sv
// Bus between the flag/branch unit and the pipeline: EX flag source, ID branch operands, redirect outputs.
// FLAG_BRANCH_STATS_EN adds the statistics counter outputs.
interface flag_branch_unit_if;
    localparam int unsigned FLAG_W = 4;
`ifdef FLAG_BRANCH_STATS_EN
    localparam int unsigned CNT_W = 32;
`endif

    logic              ex_valid;
    logic              ex_set_flags;
    logic [FLAG_W-1:0] ex_flags;
    logic              id_valid;
    logic [2:0]        id_br_type;
    logic [3:0]        id_cond;
    logic              id_rt_zero;
    logic              take_branch;
    logic              flush;
    logic [FLAG_W-1:0] flags_q;
`ifdef FLAG_BRANCH_STATS_EN
    logic [CNT_W-1:0]  br_resolved;
    logic [CNT_W-1:0]  br_taken;
`endif

    modport master (
        output ex_valid, ex_set_flags, ex_flags,
        output id_valid, id_br_type, id_cond, id_rt_zero,
        input  take_branch, flush, flags_q
`ifdef FLAG_BRANCH_STATS_EN
        , input br_resolved, br_taken
`endif
    );

    modport slave (
        input  ex_valid, ex_set_flags, ex_flags,
        input  id_valid, id_br_type, id_cond, id_rt_zero,
        output take_branch, flush, flags_q
`ifdef FLAG_BRANCH_STATS_EN
        , output br_resolved, br_taken
`endif
    );
endinterface

// File: rtl/flag_branch_unit.sv
// NZCV flag register and ID-stage LEGv8 branch resolver with a one-cycle redirect/squash FSM.
// Optional statistics counters are enabled by defining FLAG_BRANCH_STATS_EN.
module flag_branch_unit (
    input  logic               clk,
    input  logic               reset,
    flag_branch_unit_if.slave  bus
);
    localparam int unsigned FLAG_W = 4;
`ifdef FLAG_BRANCH_STATS_EN
    localparam int unsigned CNT_W  = 32;
`endif

    localparam logic [2:0] BR_B     = 3'b001;
    localparam logic [2:0] BR_CBZ   = 3'b010;
    localparam logic [2:0] BR_CBNZ  = 3'b011;
    localparam logic [2:0] BR_BCOND = 3'b100;

    typedef enum logic [0:0] {IDLE = 1'b0, REDIRECT = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              take_branch_q, take_branch_d;
    logic              flush_q, flush_d;
    logic [FLAG_W-1:0] eff;
    logic              flag_wr;
    logic              cond_true;
    logic              taken;
    logic              br_valid_type;

    // ARM condition codes evaluated on {N,Z,C,V}
    function automatic logic eval_cond(input logic [3:0] cond, input logic [FLAG_W-1:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'b0000: eval_cond = z;
            4'b0001: eval_cond = !z;
            4'b0010: eval_cond = c;
            4'b0011: eval_cond = !c;
            4'b0100: eval_cond = n;
            4'b0101: eval_cond = !n;
            4'b0110: eval_cond = v;
            4'b0111: eval_cond = !v;
            4'b1000: eval_cond = c & !z;
            4'b1001: eval_cond = !(c & !z);
            4'b1010: eval_cond = (n == v);
            4'b1011: eval_cond = (n != v);
            4'b1100: eval_cond = !z & (n == v);
            4'b1101: eval_cond = !(!z & (n == v));
            default: eval_cond = 1'b1;
        endcase
    endfunction

    // Flag forwarding and branch resolution
    always_comb begin
        flag_wr       = bus.ex_valid & bus.ex_set_flags;
        eff           = flag_wr ? bus.ex_flags : flags_q;
        cond_true     = eval_cond(bus.id_cond, eff);
        br_valid_type = 1'b0;
        taken         = 1'b0;
        case (bus.id_br_type)
            BR_B:     begin br_valid_type = 1'b1; taken = 1'b1;            end
            BR_CBZ:   begin br_valid_type = 1'b1; taken = bus.id_rt_zero;  end
            BR_CBNZ:  begin br_valid_type = 1'b1; taken = !bus.id_rt_zero; end
            BR_BCOND: begin br_valid_type = 1'b1; taken = cond_true;       end
            default:  begin br_valid_type = 1'b0; taken = 1'b0;            end
        endcase
        taken = taken & bus.id_valid;
    end

    // Next state and registered outputs; ID is on the wrong path while in REDIRECT
    always_comb begin
        state_d       = state_q;
        take_branch_d = 1'b0;
        flush_d       = 1'b0;
        flags_d       = flag_wr ? bus.ex_flags : flags_q;
        case (state_q)
            IDLE: begin
                if (taken) begin
                    state_d       = REDIRECT;
                    take_branch_d = 1'b1;
                    flush_d       = 1'b1;
                end
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            flags_q       <= '0;
            take_branch_q <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            flags_q       <= flags_d;
            take_branch_q <= take_branch_d;
            flush_q       <= flush_d;
        end
    end

    assign bus.take_branch = take_branch_q;
    assign bus.flush       = flush_q;
    assign bus.flags_q     = flags_q;

`ifdef FLAG_BRANCH_STATS_EN
    logic [CNT_W-1:0] br_resolved_q, br_resolved_d;
    logic [CNT_W-1:0] br_taken_q, br_taken_d;

    // Counters only see branches resolved in IDLE; wrap naturally
    always_comb begin
        br_resolved_d = br_resolved_q;
        br_taken_d    = br_taken_q;
        if (state_q == IDLE && bus.id_valid && br_valid_type)
            br_resolved_d = br_resolved_q + CNT_W'(1);
        if (state_q == IDLE && taken)
            br_taken_d = br_taken_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_resolved_q <= '0;
            br_taken_q    <= '0;
        end else begin
            br_resolved_q <= br_resolved_d;
            br_taken_q    <= br_taken_d;
        end
    end

    assign bus.br_resolved = br_resolved_q;
    assign bus.br_taken    = br_taken_q;
`else
    logic unused_br_valid_type;
    assign unused_br_valid_type = br_valid_type;
`endif
endmodule
